matrix_stream_tx: RTL

Transmit side of the pivot-selection stream. Holds an N_STOCKS x N_STOCKS signed matrix that the host loads through a register-style write port. On a start pulse it emits all N_STOCKS*N_STOCKS elements as one contiguous valid-qualified beat stream into the pivot selector. Because the selector has no ready signal and treats a missing valid as end-of-frame, this block must never insert bubbles inside a frame. It must also enforce a minimum idle gap between frames.

---
 rtl/matrix_stream_tx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/matrix_stream_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_stream_tx                                             |
// | Description : Streams an N_STOCKS x N_STOCKS signed matrix as one gap-free |
// |               valid-qualified frame, with an enforced idle gap after it.   |
// | Build option: DIAG_MASK_EN - diagonal beats carry the most negative value  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matrix_stream_tx #(
    parameter int WIDTH      = 16,
    parameter int N_STOCKS   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(N_STOCKS)-1:0] wr_row,
    input  logic [$clog2(N_STOCKS)-1:0] wr_col,
    input  logic [WIDTH-1:0]            wr_data,
    output logic                        wr_drop,
    input  logic                        start,
    output logic                        busy,
    output logic                        axiov,
    output logic [WIDTH-1:0]            axiod,
    output logic                        done
);

    localparam int c_IDX_W = $clog2(N_STOCKS);
    localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(N_STOCKS - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_IDX_W-1:0]   r_row_q, w_row_d;
    logic [c_IDX_W-1:0]   r_col_q, w_col_d;
    logic [c_GAP_W-1:0]   r_gap_q, w_gap_d;
    logic                 r_busy_q, w_busy_d;
    logic                 r_axiov_q, w_axiov_d;
    logic [WIDTH-1:0]     r_axiod_q, w_axiod_d;
    logic                 r_done_q, w_done_d;
    logic                 r_wr_drop_q, w_wr_drop_d;
    logic [WIDTH-1:0]     r_mem_q [N_STOCKS][N_STOCKS];
    logic [WIDTH-1:0]     w_mem_d [N_STOCKS][N_STOCKS];
    logic [WIDTH-1:0]     w_beat;
    logic                 w_wr_in_range;

    generate
        if (N_STOCKS == (1 << c_IDX_W)) begin : g_pow2_range
            assign w_wr_in_range = 1'b1;
        end else begin : g_range_check
            assign w_wr_in_range = (int'(wr_row) < N_STOCKS) && (int'(wr_col) < N_STOCKS);
        end
    endgenerate

    // The first beat reads the post-write view so a write issued with start is streamed.
    always_comb begin
        w_mem_d = r_mem_q;
        if (wr_en && (r_state_q == ST_IDLE) && w_wr_in_range) begin
            w_mem_d[wr_row][wr_col] = wr_data;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_row_d     = r_row_q;
        w_col_d     = r_col_q;
        w_gap_d     = r_gap_q;
        w_busy_d    = r_busy_q;
        w_axiov_d   = 1'b0;
        w_done_d    = 1'b0;
        w_wr_drop_d = wr_en && (r_state_q != ST_IDLE);
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_STREAM;
                    w_busy_d  = 1'b1;
                    w_row_d   = '0;
                    w_col_d   = '0;
                    w_axiov_d = 1'b1;
                end
            end
            ST_STREAM: begin
                if ((r_row_q == c_LAST) && (r_col_q == c_LAST)) begin
                    w_state_d = ST_GAP;
                    w_done_d  = 1'b1;
                    w_gap_d   = c_GAP_W'(1);
                end else begin
                    w_axiov_d = 1'b1;
                    if (r_row_q == c_LAST) begin
                        w_row_d = '0;
                        w_col_d = r_col_q + 1'b1;
                    end else begin
                        w_row_d = r_row_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // The done cycle already counts as the first idle cycle.
                if (r_gap_q == c_GAP_LAST) begin
                    w_state_d = ST_IDLE;
                    w_busy_d  = 1'b0;
                    w_gap_d   = '0;
                end else begin
                    w_gap_d = r_gap_q + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

`ifdef DIAG_MASK_EN
    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_beat = (w_row_d == w_col_d) ? c_MOST_NEG : w_mem_d[w_row_d][w_col_d];
`else
    assign w_beat = w_mem_d[w_row_d][w_col_d];
`endif

    assign w_axiod_d = w_axiov_d ? w_beat : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q   <= ST_IDLE;
            r_row_q     <= '0;
            r_col_q     <= '0;
            r_gap_q     <= '0;
            r_busy_q    <= 1'b0;
            r_axiov_q   <= 1'b0;
            r_axiod_q   <= '0;
            r_done_q    <= 1'b0;
            r_wr_drop_q <= 1'b0;
            r_mem_q     <= '{default: '0};
        end else begin
            r_state_q   <= w_state_d;
            r_row_q     <= w_row_d;
            r_col_q     <= w_col_d;
            r_gap_q     <= w_gap_d;
            r_busy_q    <= w_busy_d;
            r_axiov_q   <= w_axiov_d;
            r_axiod_q   <= w_axiod_d;
            r_done_q    <= w_done_d;
            r_wr_drop_q <= w_wr_drop_d;
            r_mem_q     <= w_mem_d;
        end
    end

    assign busy    = r_busy_q;
    assign axiov   = r_axiov_q;
    assign axiod   = r_axiod_q;
    assign done    = r_done_q;
    assign wr_drop = r_wr_drop_q;

endmodule
`default_nettype wire
